ifm_pingpong_buffer: RTL and testbench
======================================

# ifm_pingpong_buffer

Parametrised double-buffered input-feature-map store between two LeNet5 layers. It holds NUMBER_OF_IFM maps of IFM_SIZE×IFM_SIZE words per bank. The previous layer fills one bank while the next layer reads the other over two read ports. An internal handshake FSM replaces the externally driven bank select: it swaps banks itself, stalls the producer when both banks are full, and flags protocol violations.

## Interface
- DATA_WIDTH, 32, word width
- IFM_SIZE, 14, map side length
- NUMBER_OF_IFM, 2, maps per bank
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), in-map address width
- IFM_INDEX_SIZE, max(1,$clog2(NUMBER_OF_IFM)), map-index width
- ADDRESS_SIZE_BANK, $clog2(NUMBER_OF_IFM*IFM_SIZE*IFM_SIZE), physical bank address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  producer write strobe
- wr_ifm_index  in  IFM_INDEX_SIZE  map selected for write and read-back
- wr_address  in  ADDRESS_SIZE_IFM  in-map write address
- wr_data  in  DATA_WIDTH  write data
- rb_en  in  1  producer read-back strobe (partial-sum accumulation)
- rb_address  in  ADDRESS_SIZE_IFM  read-back address, same map index as write
- rb_data  out  DATA_WIDTH  read-back data
- wr_done  in  1  one-cycle pulse: producer bank complete
- wr_ready  out  1  producer bank writable
- rd_en_A, rd_en_B  in  1 each  consumer read strobes
- rd_ifm_index  in  IFM_INDEX_SIZE  map selected for both consumer ports
- rd_address_A, rd_address_B  in  ADDRESS_SIZE_IFM each  consumer addresses
- rd_data_A, rd_data_B  out  DATA_WIDTH each  consumer data
- rd_valid  out  1  consumer bank holds a complete frame
- rd_done  in  1  one-cycle pulse: consumer finished with bank
- ifm_sel  out  1  current producer bank (0 = bank 0); consumer bank = ~ifm_sel
- protocol_error  out  1  sticky violation flag, cleared only by rst

## Operation
- Physical address = index*IFM_SIZE*IFM_SIZE + in-map address, width ADDRESS_SIZE_BANK. An index ≥ NUMBER_OF_IFM or address ≥ IFM_SIZE² blocks the write, leaves read data unchanged, and sets protocol_error.
- Each bank is a true dual-port RAM:
  - Producer bank: port A takes writes, port B takes read-back.
  - Consumer bank: port A serves rd_*_A, port B serves rd_*_B.
- FSM states (full flag of producer bank, full flag of consumer bank):
  - FILL (0,0): wr_ready=1, rd_valid=0. wr_done: toggle ifm_sel, go to OVERLAP. rd_done is ignored and sets protocol_error.
  - OVERLAP (0,1): wr_ready=1, rd_valid=1.
    - wr_done and rd_done together: toggle ifm_sel, stay in OVERLAP.
    - wr_done only: go to STALL.
    - rd_done only: go to FILL.
  - STALL (1,1): wr_ready=0, rd_valid=1.
    - rd_done: toggle ifm_sel, go to OVERLAP.
    - wr_done is ignored and sets protocol_error.
    - A rd_done arriving with wr_done in the same cycle takes the rd_done transition.
- wr_en while wr_ready=0: write dropped, protocol_error set. rb_en is still honoured.
- rd_en_A/B while rd_valid=0: read suppressed, rd_data holds, protocol_error set.
- Memory contents are not cleared by reset or by a swap. Producers must overwrite every used location.

## Timing
- Reset values:
  - state FILL, ifm_sel=0, wr_ready=1, rd_valid=0, protocol_error=0.
  - rd_data_A, rd_data_B and rb_data = 0.
- Read latency is 1 cycle on all three read ports. Data is registered and holds its value until the next enabled read.
- The bank used to route read data is captured on the cycle the read is issued. A read issued on the cycle of a swap returns data from the pre-swap bank.
- Write-then-read: a write lands at the clock edge. Read-back of the same address on the same cycle returns old data (read-first); on the next cycle it returns new data.
- wr_ready, rd_valid and ifm_sel update on the edge after the pulse that changes them. Writes are accepted on the cycle of wr_done itself and go to the old bank.
- rst asserted mid-frame: the FSM returns to FILL on the next edge. Any in-flight read returns 0 and the frame is discarded.
- Throughput: one write plus one read-back plus two consumer reads per cycle, with no bubbles across a swap.

## Test plan
- Fill after reset: write bank 0 with map0[a]=a and map1[a]=1000+a, then pulse wr_done. Expect ifm_sel=1 and rd_valid=1 next cycle. Reading A at map1/addr 5 and B at map1/addr 195 gives 1005 and 1195 one cycle later.
- Stall: fill the second frame and pulse wr_done without rd_done. Expect wr_ready=0. A further wr_en is dropped, the bank contents are unchanged and protocol_error=1. Then pulse rd_done: expect the swap, wr_ready=1 and ifm_sel=0.
- Simultaneous wr_done and rd_done in OVERLAP: expect ifm_sel to toggle, state to stay OVERLAP, and rd_valid to stay 1 with the new frame's data.
- Read-back accumulate: write 7 to addr 10 at cycle n with rb_en at addr 10 at cycle n. Expect rb_data=old value at n+1. A re-read at n+1 returns 7 at n+2.
- Swap-boundary read: issue rd_en_A on the swap cycle. Expect the data to come from the old consumer bank; the read on the next cycle comes from the new bank.
- Reset mid-OVERLAP: assert rst for one cycle. Expect ifm_sel=0, wr_ready=1, rd_valid=0, rd_data_A=rd_data_B=0 and protocol_error=0.

Source files
------------

// File: rtl/ifm_pingpong_buffer_if.sv
// Producer/consumer handshake and data bus of the IFM ping-pong buffer.
// master = layer-side driver (producer + consumer), slave = the buffer itself.
interface ifm_pingpong_buffer_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDRESS_SIZE_IFM = 8,
    parameter int IFM_INDEX_SIZE   = 1
);
    // producer side
    logic                        wr_en;
    logic [IFM_INDEX_SIZE-1:0]   wr_ifm_index;
    logic [ADDRESS_SIZE_IFM-1:0] wr_address;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic                        rb_en;
    logic [ADDRESS_SIZE_IFM-1:0] rb_address;
    logic [DATA_WIDTH-1:0]       rb_data;
    logic                        wr_done;
    logic                        wr_ready;
    // consumer side
    logic                        rd_en_A;
    logic                        rd_en_B;
    logic [IFM_INDEX_SIZE-1:0]   rd_ifm_index;
    logic [ADDRESS_SIZE_IFM-1:0] rd_address_A;
    logic [ADDRESS_SIZE_IFM-1:0] rd_address_B;
    logic [DATA_WIDTH-1:0]       rd_data_A;
    logic [DATA_WIDTH-1:0]       rd_data_B;
    logic                        rd_valid;
    logic                        rd_done;
    // status
    logic                        ifm_sel;
    logic                        protocol_error;

    modport master (
        output wr_en, wr_ifm_index, wr_address, wr_data, rb_en, rb_address, wr_done,
        output rd_en_A, rd_en_B, rd_ifm_index, rd_address_A, rd_address_B, rd_done,
        input  rb_data, wr_ready, rd_data_A, rd_data_B, rd_valid, ifm_sel, protocol_error
    );

    modport slave (
        input  wr_en, wr_ifm_index, wr_address, wr_data, rb_en, rb_address, wr_done,
        input  rd_en_A, rd_en_B, rd_ifm_index, rd_address_A, rd_address_B, rd_done,
        output rb_data, wr_ready, rd_data_A, rd_data_B, rd_valid, ifm_sel, protocol_error
    );
endinterface

// File: rtl/ifm_pingpong_buffer.sv
// Double-buffered IFM store: producer fills bank ifm_sel while the consumer reads ~ifm_sel.
// A small FSM tracks both banks' full flags, swaps them and flags handshake misuse.
module ifm_pingpong_buffer #(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_SIZE          = 14,
    parameter int NUMBER_OF_IFM     = 2,
    parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE*IFM_SIZE),
    parameter int IFM_INDEX_SIZE    = (NUMBER_OF_IFM > 1) ? $clog2(NUMBER_OF_IFM) : 1,
    parameter int ADDRESS_SIZE_BANK = $clog2(NUMBER_OF_IFM*IFM_SIZE*IFM_SIZE)
) (
    input logic                clk,
    input logic                rst,
    ifm_pingpong_buffer_if.slave bus
);
    localparam int MAP_WORDS  = IFM_SIZE*IFM_SIZE;
    localparam int BANK_WORDS = NUMBER_OF_IFM*MAP_WORDS;

    typedef enum logic [1:0] {FILL, OVERLAP, STALL} state_t;

    function automatic logic in_range(input logic [IFM_INDEX_SIZE-1:0]   idx,
                                      input logic [ADDRESS_SIZE_IFM-1:0] addr);
        return (int'(idx) < NUMBER_OF_IFM) && (int'(addr) < MAP_WORDS);
    endfunction

    function automatic logic [ADDRESS_SIZE_BANK-1:0] phys(input logic [IFM_INDEX_SIZE-1:0]   idx,
                                                          input logic [ADDRESS_SIZE_IFM-1:0] addr);
        return ADDRESS_SIZE_BANK'(int'(idx)*MAP_WORDS + int'(addr));
    endfunction

    state_t                state, state_nxt;
    logic                  ifm_sel, sel_toggle, fsm_err;
    logic                  wr_ready, rd_valid, cons_bank;
    logic                  wr_ok, rb_ok, rd_a_ok, rd_b_ok, err_now, perr;
    logic [DATA_WIDTH-1:0] rb_q, rd_a_q, rd_b_q;

    // Two banks, each a true dual-port RAM; bank index is the ping-pong side.
    logic [DATA_WIDTH-1:0] mem [2][BANK_WORDS];

    assign wr_ready  = (state != STALL);
    assign rd_valid  = (state != FILL);
    assign cons_bank = ~ifm_sel;

    assign wr_ok   = bus.wr_en   && wr_ready && in_range(bus.wr_ifm_index, bus.wr_address);
    assign rb_ok   = bus.rb_en   && in_range(bus.wr_ifm_index, bus.rb_address);
    assign rd_a_ok = bus.rd_en_A && rd_valid && in_range(bus.rd_ifm_index, bus.rd_address_A);
    assign rd_b_ok = bus.rd_en_B && rd_valid && in_range(bus.rd_ifm_index, bus.rd_address_B);

    assign err_now = fsm_err
                   || (bus.wr_en   && !(wr_ready && in_range(bus.wr_ifm_index, bus.wr_address)))
                   || (bus.rb_en   && !in_range(bus.wr_ifm_index, bus.rb_address))
                   || (bus.rd_en_A && !(rd_valid && in_range(bus.rd_ifm_index, bus.rd_address_A)))
                   || (bus.rd_en_B && !(rd_valid && in_range(bus.rd_ifm_index, bus.rd_address_B)));

    always_comb begin
        state_nxt  = state;
        sel_toggle = 1'b0;
        fsm_err    = 1'b0;
        case (state)
            FILL: begin
                fsm_err = bus.rd_done;
                if (bus.wr_done) begin
                    sel_toggle = 1'b1;
                    state_nxt  = OVERLAP;
                end
            end
            OVERLAP: begin
                if (bus.wr_done && bus.rd_done) sel_toggle = 1'b1;
                else if (bus.wr_done)           state_nxt  = STALL;
                else if (bus.rd_done)           state_nxt  = FILL;
            end
            STALL: begin
                fsm_err = bus.wr_done;
                if (bus.rd_done) begin
                    sel_toggle = 1'b1;
                    state_nxt  = OVERLAP;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            ifm_sel <= 1'b0;
            perr    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sel_toggle) ifm_sel <= ~ifm_sel;
            if (err_now)    perr    <= 1'b1;
        end
    end

    // Contents survive reset and swaps; producers overwrite every used word.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[ifm_sel][phys(bus.wr_ifm_index, bus.wr_address)] <= bus.wr_data;
    end

    // Read-first: same-cycle read-back sees the pre-write word. The bank is
    // chosen by the ifm_sel in effect when the read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q   <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (rb_ok)   rb_q   <= mem[ifm_sel][phys(bus.wr_ifm_index, bus.rb_address)];
            if (rd_a_ok) rd_a_q <= mem[cons_bank][phys(bus.rd_ifm_index, bus.rd_address_A)];
            if (rd_b_ok) rd_b_q <= mem[cons_bank][phys(bus.rd_ifm_index, bus.rd_address_B)];
        end
    end

    assign bus.rb_data        = rb_q;
    assign bus.rd_data_A      = rd_a_q;
    assign bus.rd_data_B      = rd_b_q;
    assign bus.wr_ready       = wr_ready;
    assign bus.rd_valid       = rd_valid;
    assign bus.ifm_sel        = ifm_sel;
    assign bus.protocol_error = perr;
endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Scoreboard bench for ifm_pingpong_buffer: reads push expected words, which are
// popped and compared one cycle later; status flags are checked directly.
module tb_ifm_pingpong_buffer;
    localparam int DW    = 32;
    localparam int SZ    = 14;
    localparam int N     = 2;
    localparam int AW    = $clog2(SZ*SZ);
    localparam int IW    = 1;
    localparam int WORDS = SZ*SZ;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifm_pingpong_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE_IFM(AW), .IFM_INDEX_SIZE(IW)) bus ();

    ifm_pingpong_buffer #(
        .DATA_WIDTH(DW), .IFM_SIZE(SZ), .NUMBER_OF_IFM(N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             port;   // 0 = rd A, 1 = rd B, 2 = read-back
        logic [DW-1:0]  exp;
        string          tag;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Frame/map/address encoded into the data word so every read is self-describing.
    function automatic logic [DW-1:0] pat(input int frame, input int idx, input int a);
        return DW'(frame*10000 + idx*1000 + a);
    endfunction

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.port)
                0:       chk(e.tag, bus.rd_data_A, e.exp);
                1:       chk(e.tag, bus.rd_data_B, e.exp);
                default: chk(e.tag, bus.rb_data,   e.exp);
            endcase
        end
        bus.wr_en   = 1'b0;
        bus.rb_en   = 1'b0;
        bus.rd_en_A = 1'b0;
        bus.rd_en_B = 1'b0;
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
    endtask

    task automatic issue_a(input int addr, input logic [DW-1:0] exp, input string tag);
        bus.rd_en_A      = 1'b1;
        bus.rd_address_A = AW'(addr);
        sbq.push_back('{port: 0, exp: exp, tag: tag});
    endtask

    task automatic issue_b(input int addr, input logic [DW-1:0] exp, input string tag);
        bus.rd_en_B      = 1'b1;
        bus.rd_address_B = AW'(addr);
        sbq.push_back('{port: 1, exp: exp, tag: tag});
    endtask

    task automatic issue_rb(input int idx, input int addr, input logic [DW-1:0] exp, input string tag);
        bus.rb_en        = 1'b1;
        bus.wr_ifm_index = IW'(idx);
        bus.rb_address   = AW'(addr);
        sbq.push_back('{port: 2, exp: exp, tag: tag});
    endtask

    task automatic write(input int idx, input int addr, input logic [DW-1:0] data);
        bus.wr_en        = 1'b1;
        bus.wr_ifm_index = IW'(idx);
        bus.wr_address   = AW'(addr);
        bus.wr_data      = data;
    endtask

    // Fill a whole bank with frame `frame`; the done pulses ride on the last write.
    // With ovl set, the consumer concurrently streams map 0 of the previous frame.
    task automatic fill(input int frame, input bit dw, input bit dr, input bit ovl);
        for (int idx = 0; idx < N; idx++) begin
            for (int a = 0; a < WORDS; a++) begin
                write(idx, a, pat(frame, idx, a));
                if (ovl) begin
                    bus.rd_ifm_index = '0;
                    issue_a(a, pat(frame-1, 0, a), "ovl_rd_A");
                    issue_b(WORDS-1-a, pat(frame-1, 0, WORDS-1-a), "ovl_rd_B");
                end
                if (idx == N-1 && a == WORDS-1) begin
                    bus.wr_done = dw;
                    bus.rd_done = dr;
                end
                tick();
            end
        end
    endtask

    task automatic status(input string tag, input logic sel, input logic wrdy,
                          input logic rvld, input logic perr);
        chk({tag, "_sel"},  DW'(bus.ifm_sel),        DW'(sel));
        chk({tag, "_wrdy"}, DW'(bus.wr_ready),       DW'(wrdy));
        chk({tag, "_rvld"}, DW'(bus.rd_valid),       DW'(rvld));
        chk({tag, "_perr"}, DW'(bus.protocol_error), DW'(perr));
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_ifm_index = '0; bus.wr_address = '0; bus.wr_data = '0;
        bus.rb_en = 0; bus.rb_address = '0; bus.wr_done = 0;
        bus.rd_en_A = 0; bus.rd_en_B = 0; bus.rd_ifm_index = '0;
        bus.rd_address_A = '0; bus.rd_address_B = '0; bus.rd_done = 0;

        rst = 1'b1;
        tick();
        tick();
        status("reset", 0, 1, 0, 0);
        chk("reset_rdA", bus.rd_data_A, '0);
        chk("reset_rdB", bus.rd_data_B, '0);
        chk("reset_rb",  bus.rb_data,   '0);
        rst = 1'b0;

        // frame 0 into bank 0, wr_done with the last write
        fill(0, 1, 0, 0);
        status("fill0", 1, 1, 1, 0);
        bus.rd_ifm_index = IW'(1);
        issue_a(5,   pat(0, 1, 5),   "first_rd_A");
        issue_b(195, pat(0, 1, 195), "first_rd_B");
        tick();

        // frame 1 into bank 1 while streaming frame 0; no rd_done -> stall
        fill(1, 1, 0, 1);
        status("stall", 1, 0, 1, 0);
        write(0, 3, 32'hDEAD);
        tick();
        chk("stall_drop_perr", DW'(bus.protocol_error), DW'(1'b1));
        issue_rb(0, 3, pat(1, 0, 3), "stall_rb_unchanged");
        tick();

        // rd_done releases the stall; a read on the swap cycle sees the old bank
        bus.rd_done      = 1'b1;
        bus.rd_ifm_index = '0;
        issue_a(20, pat(0, 0, 20), "swap_old_bank");
        tick();
        status("unstall", 0, 1, 1, 1);
        issue_a(20, pat(1, 0, 20), "swap_new_bank");
        tick();

        // read-first accumulate on producer bank 0
        write(0, 10, 32'd7);
        issue_rb(0, 10, pat(0, 0, 10), "rb_old");
        tick();
        issue_rb(0, 10, 32'd7, "rb_new");
        tick();

        // frame 2 into bank 0; wr_done and rd_done together keep OVERLAP
        fill(2, 1, 1, 1);
        status("both_done", 1, 1, 1, 1);
        bus.rd_ifm_index = IW'(1);
        issue_a(50, pat(2, 1, 50), "both_done_rd");
        tick();

        // reset mid-OVERLAP with reads in flight
        rst = 1'b1;
        issue_a(50, '0, "rst_inflight_A");
        issue_b(60, '0, "rst_inflight_B");
        tick();
        rst = 1'b0;
        status("mid_rst", 0, 1, 0, 0);
        chk("mid_rst_rb", bus.rb_data, '0);

        // read while no frame is valid: suppressed and flagged
        issue_a(5, '0, "rd_suppressed");
        tick();
        chk("rd_invalid_perr", DW'(bus.protocol_error), DW'(1'b1));

        // out-of-range write address must not alias into map 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_perr", DW'(bus.protocol_error), DW'(1'b0));
        write(0, 200, 32'hBAD);
        tick();
        chk("oor_perr", DW'(bus.protocol_error), DW'(1'b1));
        issue_rb(1, 4, pat(2, 1, 4), "oor_no_alias");
        tick();

        // rd_done in FILL is a violation and changes nothing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd_done = 1'b1;
        tick();
        status("fill_rd_done", 0, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
